// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq: issue side (in_*) and writeback side (out_*).
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       OP;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             Overflow;

  modport master (
    output in_valid, OP, src1, src2, out_ready,
    input  in_ready, out_valid, alu_result, Overflow
  );

  modport slave (
    input  in_valid, OP, src1, src2, out_ready,
    output in_ready, out_valid, alu_result, Overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops registered behind valid/ready, plus an iterative
// shift-and-add multiplier that holds off issue until its product is registered.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     enable,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW + 1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW + 1)'(1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_result;
  logic               r_ovf;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW:0]       r_count;

  logic               w_inReady;
  logic               w_handshake;
  logic               w_isMul;
  logic               w_mulLast;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_aluRes;
  logic               w_aluOvf;
  logic [2*WIDTH-1:0] w_accNext;

  assign w_inReady   = enable & ~rst &
                       ((r_state == ST_IDLE) | ((r_state == ST_DONE) & bus.out_ready));
  assign w_handshake = bus.in_valid & w_inReady;
  assign w_isMul     = (bus.OP == OP_MUL);
  assign w_mulLast   = (r_count == CNT_ONE);
  assign w_accNext   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  assign bus.in_ready   = w_inReady;
  assign bus.out_valid  = enable & (r_state == ST_DONE);
  assign bus.alu_result = r_result;
  assign bus.Overflow   = r_ovf;

  always_comb begin
    w_sum    = bus.src1 + bus.src2;
    w_diff   = bus.src1 - bus.src2;
    w_shamt  = bus.src2[SHW-1:0];
    w_aluRes = '0;
    w_aluOvf = 1'b0;
    unique case (bus.OP)
      OP_ADD: begin
        w_aluRes = w_sum;
        w_aluOvf = (bus.src1[WIDTH-1] == bus.src2[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != bus.src1[WIDTH-1]);
      end
      OP_SUB: begin
        w_aluRes = w_diff;
        w_aluOvf = (bus.src1[WIDTH-1] != bus.src2[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != bus.src1[WIDTH-1]);
      end
      OP_AND:  w_aluRes = bus.src1 & bus.src2;
      OP_OR:   w_aluRes = bus.src1 | bus.src2;
      OP_XOR:  w_aluRes = bus.src1 ^ bus.src2;
      OP_SLT:  w_aluRes = {{(WIDTH-1){1'b0}}, ($signed(bus.src1) < $signed(bus.src2))};
      OP_SLL:  w_aluRes = bus.src1 << w_shamt;
      OP_SRL:  w_aluRes = bus.src1 >> w_shamt;
      OP_SRA:  w_aluRes = $signed(bus.src1) >>> w_shamt;
      default: w_aluRes = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (enable) begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_handshake) w_nextState = w_isMul ? ST_MUL : ST_DONE;
      end
      ST_MUL: begin
        if (w_mulLast) w_nextState = ST_DONE;
      end
      ST_DONE: begin
        if (w_handshake)        w_nextState = w_isMul ? ST_MUL : ST_DONE;
        else if (bus.out_ready) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // A MUL handshake leaves r_result untouched; the old value is hidden because out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (enable) begin
      if (w_handshake) begin
        if (w_isMul) begin
          r_mcand  <= {{WIDTH{1'b0}}, bus.src1};
          r_mplier <= bus.src2;
          r_acc    <= '0;
          r_count  <= CNT_INIT;
        end else begin
          r_result <= w_aluRes;
          r_ovf    <= w_aluOvf;
        end
      end else if (r_state == ST_MUL) begin
        r_acc    <= w_accNext;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count - CNT_ONE;
        if (w_mulLast) begin
          r_result <= w_accNext[WIDTH-1:0];
          r_ovf    <= |w_accNext[2*WIDTH-1:WIDTH];
        end
      end
    end
  end
endmodule
